seq_divider_6by3: RTL and testbench

SEQ_DIVIDER_6BY3 -- requirements
Module: seq_divider_6by3

---
 rtl/seq_divider_6by3_if.sv | 10 +
 rtl/seq_divider_6by3.sv | 147 ++++++++++++++
 tb/tb_seq_divider_6by3.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seq_divider_6by3_if.sv
// Operand/result bus of the sequential divider.
// io_in[7:2] carries strobe, beat data, result select and a spare bit;
// io_in[0] (clock) and io_in[1] (reset) are plain ports on the divider.
interface seq_divider_6by3_if;
  logic [7:2] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/seq_divider_6by3.sv
// Sequential 6-by-3 restoring divider loaded by three strobed 3-bit beats
// (dividend high, dividend low, divisor). One quotient bit per clock, MSB first.
// Optional macro SEQ_DIVIDER_SYNC_EN puts a two-flop synchronizer on the strobe.
module seq_divider_6by3 #(
  parameter int DIVIDEND_W = 6,
  parameter int DIVISOR_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  seq_divider_6by3_if.slave  bus
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [2:0] {IDLE, GOT_HI, GOT_LO, CALC, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    prev_q;
  logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
  logic [DIVIDEND_W-1:0]   quo_q, quo_d;
  logic [DIVISOR_W-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    done_q, done_d;

  logic                    strb;
  logic                    strb_edge;
  logic [DIVISOR_W-1:0]    beat;
  logic                    sel;
  logic                    unused_spare;
  logic [DIVISOR_W:0]      trial;
  logic [DIVISOR_W:0]      diff;
  logic                    fits;
  logic [DIVIDEND_W-1:0]   result;

  assign beat         = bus.io_in[5:3];
  assign sel          = bus.io_in[6];
  assign unused_spare = bus.io_in[7];

`ifdef SEQ_DIVIDER_SYNC_EN
  logic [1:0] sync_q;
  // Two-flop strobe synchronizer; resets high so a held strobe gives no edge
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], bus.io_in[2]};
  end
  assign strb = sync_q[1];
`else
  assign strb = bus.io_in[2];
`endif

  assign strb_edge = strb & ~prev_q;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  assign trial = {rem_q, quo_q[DIVIDEND_W-1]};
  assign diff  = trial - {1'b0, dvs_q};
  assign fits  = (trial >= {1'b0, dvs_q});

  // State and datapath registers; reset wins over any edge or step
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      prev_q  <= 1'b1;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= strb;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: beat loading, divide-by-zero shortcut, iteration control
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (strb_edge) begin
          dvd_d[DIVIDEND_W-1 -: DIVISOR_W] = beat;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = GOT_HI;
        end
      end
      GOT_HI: begin
        if (strb_edge) begin
          dvd_d[DIVISOR_W-1:0] = beat;
          state_d = GOT_LO;
        end
      end
      GOT_LO: begin
        if (strb_edge) begin
          dvs_d = beat;
          if (beat == '0) begin
            quo_d   = '1;
            rem_d   = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            quo_d   = dvd_q;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Strobe edges are deliberately not looked at here
        quo_d = {quo_q[DIVIDEND_W-2:0], fits};
        rem_d = fits ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          done_d  = 1'b1;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result field mux is purely combinational; outputs are zero unless done
  assign result     = sel ? {{(DIVIDEND_W-DIVISOR_W){1'b0}}, rem_q} : quo_q;
  assign bus.io_out = done_q ? {1'b1, err_q, result} : '0;

endmodule

// File: tb/tb_seq_divider_6by3.sv
// Bench for seq_divider_6by3: arithmetic reference model checked every cycle
// plus directed runs with hand-computed results and latencies.
module tb_seq_divider_6by3;

`ifdef SEQ_DIVIDER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       strobe = 1'b0;
  logic       sel = 1'b0;
  logic [2:0] data = 3'd0;
  bit         chk_en = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  seq_divider_6by3_if bus ();
  assign bus.io_in = {1'b0, sel, data, strobe};

  seq_divider_6by3 dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: beat counting plus plain / and % arithmetic
  int m_st = 0;          // 0 idle, 1 have hi, 2 have lo, 3 dividing, 4 result shown
  int m_prev = 1, m_s1 = 1, m_s2 = 1;
  int m_a = 0, m_b = 0, m_left = 0, m_q = 0, m_r = 0, m_err = 0;

  initial begin
    int s_eff;
    bit m_edge;
    logic [7:0] exp_out;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_st = 0; m_prev = 1; m_s1 = 1; m_s2 = 1;
      end else begin
        s_eff  = (SYNC_LAT != 0) ? m_s2 : int'(strobe);
        m_edge = (s_eff == 1) && (m_prev == 0);
        m_s2 = m_s1; m_s1 = int'(strobe); m_prev = s_eff;
        case (m_st)
          0, 4: if (m_edge) begin m_a = int'(data) * 8; m_st = 1; end
          1:    if (m_edge) begin m_a = m_a + int'(data); m_st = 2; end
          2:    if (m_edge) begin
                  m_b = int'(data);
                  if (m_b == 0) begin m_q = 63; m_r = 0; m_err = 1; m_st = 4; end
                  else begin m_left = 6; m_st = 3; end
                end
          3: begin
               m_left--;
               if (m_left == 0) begin
                 m_q = m_a / m_b; m_r = m_a % m_b; m_err = 0; m_st = 4;
               end
             end
          default: m_st = 0;
        endcase
      end
      @(negedge clk);
      if (chk_en) begin
        exp_out = 8'h00;
        if (m_st == 4)
          exp_out = {1'b1, m_err[0], sel ? {3'b000, m_r[2:0]} : m_q[5:0]};
        n_cmp++;
        if (bus.io_out !== exp_out) begin
          n_bad++;
          $display("FAIL model t=%0t io_out=%h expected %h", $time, bus.io_out, exp_out);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else
      $display("ok   %s: %0d", name, act);
  endtask

  task automatic send_beat(input logic [2:0] d);
    @(posedge clk); #1 data = d; strobe = 1'b1;
    @(posedge clk); #1 strobe = 1'b0;
  endtask

  // Load three beats, measure capture-to-done latency, check both result views
  task automatic run_div(input string name, input logic [2:0] hi, input logic [2:0] lo,
                         input logic [2:0] d, input logic [5:0] eq, input logic [2:0] er,
                         input bit ee, input bit disturb);
    int n;
    send_beat(hi);
    send_beat(lo);
    @(posedge clk); #1 data = d; strobe = 1'b1;
    @(posedge clk); #1 strobe = 1'b0;
    n = 0;
    while (!bus.io_out[7] && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (disturb && n == 1) begin data = 3'd3; strobe = 1'b1; end
      if (disturb && n == 2) strobe = 1'b0;
    end
    chk_int({name, " latency"}, n, (ee ? 0 : 6) + SYNC_LAT);
    sel = 1'b0; #1;
    chk({name, " quotient"}, bus.io_out, {1'b1, ee, eq});
    sel = 1'b1; #1;
    chk({name, " remainder"}, bus.io_out, {1'b1, ee, 3'b000, er});
    sel = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk("reset io_out", bus.io_out, 8'h00);
    rst = 1'b0;
    chk_en = 1'b1;

    run_div("56/7", 3'd7, 3'd0, 3'd7, 6'd8, 3'd0, 1'b0, 1'b0);
    run_div("63/5", 3'd7, 3'd7, 3'd5, 6'd12, 3'd3, 1'b0, 1'b0);
    run_div("5/6", 3'd0, 3'd5, 3'd6, 6'd0, 3'd5, 1'b0, 1'b0);
    run_div("25/0", 3'd3, 3'd1, 3'd0, 6'h3F, 3'd0, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1 chk("div0 hold", bus.io_out, 8'hFF);

    run_div("56/7 disturbed", 3'd7, 3'd0, 3'd7, 6'd8, 3'd0, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1 chk("no queued edge", bus.io_out, 8'h88);

    // Reset at CALC step 3
    send_beat(3'd7);
    send_beat(3'd7);
    @(posedge clk); #1 data = 3'd5; strobe = 1'b1;
    @(posedge clk); #1 strobe = 1'b0;
    repeat (SYNC_LAT + 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("reset mid-calc", bus.io_out, 8'h00);
    repeat (10) @(posedge clk);
    #1 chk("idle after reset", bus.io_out, 8'h00);
    run_div("5/6 after reset", 3'd0, 3'd5, 3'd6, 6'd0, 3'd5, 1'b0, 1'b0);

    // Reset mid-load with strobe held high through reset release
    send_beat(3'd5);
    @(posedge clk); #1 strobe = 1'b1; rst = 1'b1; data = 3'd6;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 strobe = 1'b0;
    chk("held strobe no edge", bus.io_out, 8'h00);
    run_div("63/5 after held", 3'd7, 3'd7, 3'd5, 6'd12, 3'd3, 1'b0, 1'b0);
    run_div("42/4", 3'd5, 3'd2, 3'd4, 6'd10, 3'd2, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
